// File: rtl/lpc_pkg.sv
// Shared widths, defaults and arithmetic helpers for the LPC analysis front end.
package lpc_pkg;
   localparam int DATA_W_DEF = 16;
   localparam int ORDER_DEF  = 10;
   localparam int ACC_W_DEF  = 40;
   localparam int LEN_W_DEF  = 12;

   // Helpers work on a 64-bit container; accumulators must not exceed it.
   localparam int MAX_W = 64;

   function automatic int msb_index(input logic [MAX_W-1:0] v);
      int p;
      p = -1;
      for (int i = 0; i < MAX_W; i++) begin
         if (v[i]) p = i;
      end
      return p;
   endfunction

   function automatic logic signed [MAX_W-1:0] sat_to(input logic signed [MAX_W-1:0] v,
                                                      input int w);
      logic signed [MAX_W-1:0] hi;
      logic signed [MAX_W-1:0] lo;
      hi = (MAX_W'(1) <<< (w - 1)) - MAX_W'(1);
      lo = -hi - MAX_W'(1);
      if (v > hi)      return hi;
      else if (v < lo) return lo;
      else             return v;
   endfunction
endpackage

// File: rtl/lpc_block_norm.sv
// Combinational block normalisation: find MSB of R0, shift every lag by a common
// amount so R0 fits in DATA_W signed, and saturate each lag.
module lpc_block_norm import lpc_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ORDER  = ORDER_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic [(ORDER+1)*ACC_W-1:0]  raw,
   output logic [(ORDER+1)*DATA_W-1:0] lags,
   output logic [5:0]                  shift
);
   logic [MAX_W-1:0] r0_ext;
   int               p;

   assign r0_ext = MAX_W'(raw[ACC_W-1:0]);

   always_comb begin
      p     = msb_index(r0_ext);
      shift = '0;
      if (p >= DATA_W - 1) shift = 6'(p - (DATA_W - 2));
   end

   for (genvar k = 0; k <= ORDER; k++) begin : g_lag
      logic signed [ACC_W-1:0] shifted;
      assign shifted = $signed(raw[k*ACC_W +: ACC_W]) >>> shift;
      assign lags[k*DATA_W +: DATA_W] = DATA_W'(sat_to(MAX_W'(shifted), DATA_W));
   end
endmodule

// File: rtl/lpc_frame_analyzer.sv
// Frame-based autocorrelation, peak and zero-crossing accumulator with a
// one-cycle normalisation stage and a valid/ready result register.
module lpc_frame_analyzer import lpc_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ORDER  = ORDER_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   input  logic signed [DATA_W-1:0]      in_data,
   input  logic [LEN_W-1:0]              frame_len,
   input  logic [DATA_W-1:0]             peak_thr,
   input  logic [LEN_W-1:0]              zc_max,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [(ORDER+1)*DATA_W-1:0]   out_r,
   output logic [5:0]                    out_shift,
   output logic [DATA_W-1:0]             out_peak,
   output logic [LEN_W-1:0]              out_zc,
   output logic                          out_voiced,
   output logic [7:0]                    drop_count
);
   localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0]        MAX_V = ~MIN_V;

   logic [LEN_W-1:0]          n, len_q, len_eff, len_cur, zc, zc_nx, raw_zc;
   logic signed [DATA_W-1:0]  dl [ORDER];
   logic signed [ACC_W-1:0]   acc [ORDER+1];
   logic signed [ACC_W-1:0]   acc_nx [ORDER+1];
   logic [DATA_W-1:0]         abs_x, peak, peak_nx, raw_peak;
   logic [(ORDER+1)*ACC_W-1:0]  raw_r;
   logic [(ORDER+1)*DATA_W-1:0] norm_lags;
   logic [5:0]                norm_shift;
   logic                      norm_pend, last, zc_hit;

   // frame_len is only looked at on the first sample; later samples use the latch.
   assign len_eff = (frame_len == '0) ? LEN_W'(1) : frame_len;
   assign len_cur = (n == '0) ? len_eff : len_q;
   assign last    = in_valid && (n == len_cur - LEN_W'(1));

   always_comb begin
      abs_x = in_data;
      if (in_data[DATA_W-1]) abs_x = (in_data == MIN_V) ? MAX_V : DATA_W'(-in_data);
   end

   assign peak_nx = (abs_x > peak) ? abs_x : peak;
   assign zc_hit  = (n != '0) && (in_data[DATA_W-1] != dl[0][DATA_W-1]);
   assign zc_nx   = zc + LEN_W'(zc_hit);

   for (genvar k = 0; k <= ORDER; k++) begin : g_mac
      logic signed [DATA_W-1:0]   tap;
      logic signed [2*DATA_W-1:0] prod;
      if (k == 0) begin : g_sq
         assign tap = in_data;
      end else begin : g_dl
         assign tap = dl[k-1];
      end
      assign prod      = in_data * tap;
      assign acc_nx[k] = acc[k] + ACC_W'(prod);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n         <= '0;
         len_q     <= '0;
         peak      <= '0;
         zc        <= '0;
         raw_r     <= '0;
         raw_peak  <= '0;
         raw_zc    <= '0;
         norm_pend <= 1'b0;
         for (int k = 0; k <= ORDER; k++) acc[k] <= '0;
         for (int i = 0; i < ORDER; i++) dl[i] <= '0;
      end else begin
         norm_pend <= last;
         if (last) begin
            for (int k = 0; k <= ORDER; k++) begin
               raw_r[k*ACC_W +: ACC_W] <= acc_nx[k];
               acc[k] <= '0;
            end
            for (int i = 0; i < ORDER; i++) dl[i] <= '0;
            raw_peak <= peak_nx;
            raw_zc   <= zc_nx;
            peak     <= '0;
            zc       <= '0;
            n        <= '0;
         end else if (in_valid) begin
            for (int k = 0; k <= ORDER; k++) acc[k] <= acc_nx[k];
            for (int i = ORDER - 1; i > 0; i--) dl[i] <= dl[i-1];
            dl[0] <= in_data;
            peak  <= peak_nx;
            zc    <= zc_nx;
            n     <= n + LEN_W'(1);
            if (n == '0) len_q <= len_eff;
         end
      end
   end

   lpc_block_norm #(.DATA_W(DATA_W), .ORDER(ORDER), .ACC_W(ACC_W)) u_norm (
      .raw   (raw_r),
      .lags  (norm_lags),
      .shift (norm_shift)
   );

   // A pending result is dropped only if the held one is not leaving this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_r      <= '0;
         out_shift  <= '0;
         out_peak   <= '0;
         out_zc     <= '0;
         out_voiced <= 1'b0;
         drop_count <= '0;
      end else if (norm_pend && !(out_valid && !out_ready)) begin
         out_valid  <= 1'b1;
         out_r      <= norm_lags;
         out_shift  <= norm_shift;
         out_peak   <= raw_peak;
         out_zc     <= raw_zc;
         out_voiced <= (raw_peak >= peak_thr) && (raw_zc < zc_max);
      end else if (norm_pend) begin
         if (drop_count != 8'hff) drop_count <= drop_count + 8'd1;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_lpc_frame_analyzer.sv
// Self-checking bench: directed scenarios with fixed expectations plus random
// frames compared against a frame-level autocorrelation model.
module tb_lpc_frame_analyzer;
   localparam int DATA_W = 16;
   localparam int ORDER  = 10;
   localparam int ACC_W  = 40;
   localparam int LEN_W  = 12;

   logic                        clk = 1'b0;
   logic                        rst_n = 1'b0;
   logic                        in_valid = 1'b0;
   logic signed [DATA_W-1:0]    in_data = '0;
   logic [LEN_W-1:0]            frame_len = '0;
   logic [DATA_W-1:0]           peak_thr = '0;
   logic [LEN_W-1:0]            zc_max = '0;
   logic                        out_valid;
   logic                        out_ready = 1'b1;
   logic [(ORDER+1)*DATA_W-1:0] out_r;
   logic [5:0]                  out_shift;
   logic [DATA_W-1:0]           out_peak;
   logic [LEN_W-1:0]            out_zc;
   logic                        out_voiced;
   logic [7:0]                  drop_count;

   always #5 clk = ~clk;

   lpc_frame_analyzer #(.DATA_W(DATA_W), .ORDER(ORDER), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .frame_len(frame_len), .peak_thr(peak_thr), .zc_max(zc_max),
      .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
      .out_shift(out_shift), .out_peak(out_peak), .out_zc(out_zc),
      .out_voiced(out_voiced), .drop_count(drop_count)
   );

   typedef struct {
      longint r [ORDER+1];
      int     shift;
      int     peak;
      int     zc;
      bit     voiced;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   bit   mon_en = 1'b0;

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint dut_lag(input int k);
      return longint'($signed(out_r[k*DATA_W +: DATA_W]));
   endfunction

   // Autocorrelation by definition; shift is the smallest one that brings R0 under 2^15.
   function automatic exp_t model(input int s[$], input int thr, input int zmax);
      exp_t   e;
      longint sum, v;
      int     sh, a;
      for (int k = 0; k <= ORDER; k++) begin
         sum = 0;
         for (int i = k; i < s.size(); i++) sum += longint'(s[i]) * longint'(s[i-k]);
         e.r[k] = sum;
      end
      sh = 0;
      while ((e.r[0] >>> sh) >= 32768) sh++;
      e.shift = sh;
      for (int k = 0; k <= ORDER; k++) begin
         v = e.r[k] >>> sh;
         if (v > 32767) v = 32767;
         if (v < -32768) v = -32768;
         e.r[k] = v;
      end
      e.peak = 0;
      e.zc = 0;
      for (int i = 0; i < s.size(); i++) begin
         a = (s[i] < 0) ? -s[i] : s[i];
         if (a > 32767) a = 32767;
         if (a > e.peak) e.peak = a;
         if (i > 0 && ((s[i] < 0) != (s[i-1] < 0))) e.zc++;
      end
      e.voiced = (e.peak >= thr) && (e.zc < zmax);
      return e;
   endfunction

   task automatic cmp(input string p, input exp_t e);
      for (int k = 0; k <= ORDER; k++) check($sformatf("%s lag%0d", p, k), dut_lag(k), e.r[k]);
      check({p, " shift"}, longint'(out_shift), e.shift);
      check({p, " peak"}, longint'(out_peak), e.peak);
      check({p, " zc"}, longint'(out_zc), e.zc);
      check({p, " voiced"}, longint'(out_voiced), e.voiced);
   endtask

   always @(negedge clk) begin
      if (mon_en && rst_n && out_valid && out_ready) begin : mon
         exp_t e;
         if (exp_q.size() == 0) check("unexpected result", 1, 0);
         else begin
            e = exp_q.pop_front();
            cmp("rand", e);
         end
      end
   end

   task automatic idle(input int cycles);
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input int x);
      in_valid = 1'b1;
      in_data  = x[DATA_W-1:0];
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Drives one frame; optionally scribbles frame_len mid-frame, which must be ignored.
   task automatic send_frame(input int s[$], input int len_field, input int maxgap,
                             input bit scramble);
      for (int i = 0; i < s.size(); i++) begin
         if (i == 0) frame_len = len_field[LEN_W-1:0];
         else begin
            if (maxgap > 0) idle($urandom_range(0, maxgap));
            if (scramble && $urandom_range(0, 2) == 0) frame_len = LEN_W'($urandom);
         end
         send(s[i]);
      end
   endtask

   task automatic wait_valid(input string tag);
      int i;
      for (i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      if (i == 20) check({tag, " out_valid timeout"}, 0, 1);
   endtask

   task automatic check_dc(input string p);
      longint dc [4];
      dc = '{31250, 23437, 15625, 7812};
      for (int k = 0; k <= ORDER; k++)
         check($sformatf("%s lag%0d", p, k), dut_lag(k), (k < 4) ? dc[k] : 0);
      check({p, " shift"}, longint'(out_shift), 7);
      check({p, " peak"}, longint'(out_peak), 1000);
      check({p, " zc"}, longint'(out_zc), 0);
      check({p, " voiced"}, longint'(out_voiced), 1);
   endtask

   task automatic check_cleared(input string p);
      check({p, " out_valid"}, longint'(out_valid), 0);
      check({p, " drop_count"}, longint'(drop_count), 0);
      check({p, " out_r nonzero"}, longint'(|out_r), 0);
      check({p, " shift"}, longint'(out_shift), 0);
      check({p, " peak"}, longint'(out_peak), 0);
      check({p, " zc"}, longint'(out_zc), 0);
      check({p, " voiced"}, longint'(out_voiced), 0);
   endtask

   function automatic int rand_sample();
      case ($urandom_range(0, 3))
         0:       return -32768;
         1:       return $urandom_range(0, 400) - 200;
         default: return int'($signed(16'($urandom)));
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int q[$];
      int L, eff, thr, zmax;

      peak_thr = 16'd500;
      zc_max   = 12'd2;
      #12;
      check_cleared("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(1);

      q = {};
      repeat (4) q.push_back(1000);
      send_frame(q, 4, 0, 0);
      wait_valid("dc");
      check_dc("dc");

      peak_thr = 16'd50;
      zc_max   = 12'd4;
      q = {};
      repeat (4) begin q.push_back(100); q.push_back(-100); end
      send_frame(q, 8, 0, 0);
      wait_valid("alt");
      check("alt lag0", dut_lag(0), 20000);
      check("alt lag1", dut_lag(1), -17500);
      check("alt lag2", dut_lag(2), 15000);
      check("alt shift", longint'(out_shift), 2);
      check("alt zc", longint'(out_zc), 7);
      check("alt voiced", longint'(out_voiced), 0);

      peak_thr = 16'd500;
      zc_max   = 12'd2;
      idle(2);
      out_ready = 1'b0;
      q = {};
      repeat (4) q.push_back(1000);
      send_frame(q, 4, 0, 0);
      wait_valid("bp1");
      check_dc("bp first");
      q = {};
      repeat (4) q.push_back(200);
      send_frame(q, 4, 0, 0);
      idle(3);
      check_dc("bp held");
      check("bp drop_count", longint'(drop_count), 1);
      check("bp out_valid held", longint'(out_valid), 1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp release out_valid", longint'(out_valid), 0);

      out_ready = 1'b0;
      q = {};
      repeat (4) q.push_back(1000);
      send_frame(q, 4, 0, 0);
      wait_valid("rep1");
      q = {};
      repeat (4) q.push_back(200);
      send_frame(q, 4, 0, 0);
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("replace out_valid", longint'(out_valid), 1);
      check("replace peak", longint'(out_peak), 200);
      check("replace lag0", dut_lag(0), 20000);
      check("replace shift", longint'(out_shift), 3);
      check("replace drop_count", longint'(drop_count), 1);

      idle(2);
      q = {-32768, 5};
      send_frame(q, 2, 0, 0);
      wait_valid("sat");
      check("sat peak", longint'(out_peak), 32767);
      check("sat lag0", dut_lag(0), 16384);
      check("sat lag1", dut_lag(1), -3);
      check("sat shift", longint'(out_shift), 16);
      check("sat zc", longint'(out_zc), 1);
      check("sat voiced", longint'(out_voiced), 1);

      idle(2);
      out_ready = 1'b0;
      q = {};
      repeat (4) q.push_back(1000);
      send_frame(q, 4, 0, 0);
      wait_valid("pre-reset");
      frame_len = 12'd4;
      send(1000);
      send(1000);
      #2 rst_n = 1'b0;
      #1;
      check_cleared("midreset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      q = {};
      repeat (4) q.push_back(1000);
      send_frame(q, 4, 0, 0);
      wait_valid("post-reset");
      check_dc("post-reset");

      idle(2);
      mon_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         q = {rand_sample()};
         exp_q.push_back(model(q, 500, 2));
         send_frame(q, 0, 0, 0);
      end
      idle(4);

      thr  = $urandom_range(0, 20000);
      zmax = $urandom_range(0, 20);
      peak_thr = thr[DATA_W-1:0];
      zc_max   = zmax[LEN_W-1:0];
      for (int f = 0; f < 60; f++) begin
         L   = $urandom_range(0, 24);
         eff = (L == 0) ? 1 : L;
         q = {};
         for (int i = 0; i < eff; i++) q.push_back(rand_sample());
         exp_q.push_back(model(q, thr, zmax));
         send_frame(q, L, ($urandom_range(0, 1) == 0) ? 0 : 2, 1);
         if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 3));
      end
      idle(10);
      check("results drained", longint'(exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
